div_sched: RTL and testbench

Divider sequencer for the EX stage. Accepts one divide request at a time and routes it to either the signed or the unsigned divider IP core. It handles each core's two independent AXI-Stream operand channels and captures the 64-bit result. It also absorbs pipeline flushes: an operation already handed to a core cannot be aborted, so it is drained and discarded. A one-entry result cache returns an immediate answer when a div/mod pair repeats the same operands.

---
 rtl/div_sched.sv | 195 +++++++++++++++++++
 tb/tb_div_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: divider sequencer for the EX stage.
// Takes one divide request at a time, issues its operands to the signed or unsigned divider core
// over two independent AXI-Stream channels, captures the {quot, rem} result and presents it to EX.
// Operations already handed to a core cannot be aborted, so a flush after the first operand
// handshake drains and discards that core's result. A one-entry cache answers a repeated request
// (same signedness and operands) without touching a core.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      kills the current request/response
//   req_*                      request handshake and operands from EX
//   resp_*                     result handshake back to EX (resp_ack consumes)
//   div_*_tdata                operands shared by both cores
//   sdiv_* / udiv_*            per-core operand channel valids/readies and result channel
module div_sched #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CACHE_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_src1,
  input  logic [WIDTH-1:0]   req_src2,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_quot,
  output logic [WIDTH-1:0]   resp_rem,
  input  logic               resp_ack,
  output logic [WIDTH-1:0]   div_dividend_tdata,
  output logic [WIDTH-1:0]   div_divisor_tdata,
  output logic               sdiv_dividend_tvalid,
  output logic               sdiv_divisor_tvalid,
  input  logic               sdiv_dividend_tready,
  input  logic               sdiv_divisor_tready,
  input  logic               sdiv_dout_tvalid,
  input  logic [2*WIDTH-1:0] sdiv_dout_tdata,
  output logic               udiv_dividend_tvalid,
  output logic               udiv_divisor_tvalid,
  input  logic               udiv_dividend_tready,
  input  logic               udiv_divisor_tready,
  input  logic               udiv_dout_tvalid,
  input  logic [2*WIDTH-1:0] udiv_dout_tdata
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic             sgn_q, sgn_d;
  logic             dvd_acc_q, dvd_acc_d, dvs_acc_q, dvs_acc_d;
  logic             flush_pend_q, flush_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             cv_q, cv_d, c_sgn_q, c_sgn_d;
  logic [WIDTH-1:0] c_src1_q, c_src1_d, c_src2_q, c_src2_d;
  logic [WIDTH-1:0] c_quot_q, c_quot_d, c_rem_q, c_rem_d;

  logic               dvd_tvalid, dvs_tvalid, dvd_hs, dvs_hs, dvd_done, dvs_done;
  logic               dout_v, hit;
  logic [2*WIDTH-1:0] dout_d;

  // Channel valids are decoded from registered state only.
  assign dvd_tvalid = (state_q == StIssue) && !dvd_acc_q;
  assign dvs_tvalid = (state_q == StIssue) && !dvs_acc_q;
  assign dvd_hs     = dvd_tvalid && (sgn_q ? sdiv_dividend_tready : udiv_dividend_tready);
  assign dvs_hs     = dvs_tvalid && (sgn_q ? sdiv_divisor_tready : udiv_divisor_tready);
  assign dvd_done   = dvd_acc_q || dvd_hs;
  assign dvs_done   = dvs_acc_q || dvs_hs;
  assign dout_v     = sgn_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
  assign dout_d     = sgn_q ? sdiv_dout_tdata : udiv_dout_tdata;

  assign hit = (CACHE_EN != 0) && cv_q && (c_sgn_q == req_signed) &&
               (c_src1_q == req_src1) && (c_src2_q == req_src2);

  always_comb begin
    state_d      = state_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    sgn_d        = sgn_q;
    dvd_acc_d    = dvd_acc_q;
    dvs_acc_d    = dvs_acc_q;
    flush_pend_d = flush_pend_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    cv_d         = cv_q;
    c_sgn_d      = c_sgn_q;
    c_src1_d     = c_src1_q;
    c_src2_d     = c_src2_q;
    c_quot_d     = c_quot_q;
    c_rem_d      = c_rem_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          src1_d = req_src1;
          src2_d = req_src2;
          sgn_d  = req_signed;
          if (hit) begin
            quot_d  = c_quot_q;
            rem_d   = c_rem_q;
            state_d = StDone;
          end else begin
            dvd_acc_d    = 1'b0;
            dvs_acc_d    = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        dvd_acc_d = dvd_done;
        dvs_acc_d = dvs_done;
        if (dvd_done && dvs_done) begin
          state_d = (flush || flush_pend_q) ? StDrain : StWait;
        end else if (flush) begin
          // Nothing reached the core yet: abandon. Otherwise the core already holds one operand,
          // so the other must still be sent and the result drained.
          if (!dvd_done && !dvs_done) state_d = StIdle;
          else                         flush_pend_d = 1'b1;
        end
      end
      StWait: begin
        if (flush) begin
          // A result arriving with the flush is itself the drained result.
          state_d = dout_v ? StIdle : StDrain;
        end else if (dout_v) begin
          quot_d   = dout_d[2*WIDTH-1:WIDTH];
          rem_d    = dout_d[WIDTH-1:0];
          cv_d     = 1'b1;
          c_sgn_d  = sgn_q;
          c_src1_d = src1_q;
          c_src2_d = src2_q;
          c_quot_d = dout_d[2*WIDTH-1:WIDTH];
          c_rem_d  = dout_d[WIDTH-1:0];
          state_d  = StDone;
        end
      end
      StDone: begin
        if (flush || resp_ack) state_d = StIdle;
      end
      StDrain: begin
        if (dout_v) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src1_q       <= '0;
      src2_q       <= '0;
      sgn_q        <= 1'b0;
      dvd_acc_q    <= 1'b0;
      dvs_acc_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      quot_q       <= '0;
      rem_q        <= '0;
      cv_q         <= 1'b0;
      c_sgn_q      <= 1'b0;
      c_src1_q     <= '0;
      c_src2_q     <= '0;
      c_quot_q     <= '0;
      c_rem_q      <= '0;
    end else begin
      state_q      <= state_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      sgn_q        <= sgn_d;
      dvd_acc_q    <= dvd_acc_d;
      dvs_acc_q    <= dvs_acc_d;
      flush_pend_q <= flush_pend_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      cv_q         <= cv_d;
      c_sgn_q      <= c_sgn_d;
      c_src1_q     <= c_src1_d;
      c_src2_q     <= c_src2_d;
      c_quot_q     <= c_quot_d;
      c_rem_q      <= c_rem_d;
    end
  end

  assign req_ready            = (state_q == StIdle);
  assign resp_valid           = (state_q == StDone);
  assign resp_quot            = quot_q;
  assign resp_rem             = rem_q;
  assign div_dividend_tdata   = src1_q;
  assign div_divisor_tdata    = src2_q;
  assign sdiv_dividend_tvalid = dvd_tvalid && sgn_q;
  assign sdiv_divisor_tvalid  = dvs_tvalid && sgn_q;
  assign udiv_dividend_tvalid = dvd_tvalid && !sgn_q;
  assign udiv_divisor_tvalid  = dvs_tvalid && !sgn_q;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized bench for div_sched with behavioural divider-core models and a
// scoreboard. Index 1 of the per-core arrays is the signed core, index 0 the unsigned core.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        resp_ack = 1'b0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_quot, resp_rem, dvd_tdata, dvs_tdata;
  logic        s_dvd_tv, s_dvs_tv, u_dvd_tv, u_dvs_tv;

  logic        dvd_rdy[2];
  logic        dvs_rdy[2];
  logic        dout_v[2];
  logic [63:0] dout_d[2];

  // Owned by the core-model process: cumulative handshake/valid/result counts per core.
  int hs_dvd[2];
  int hs_dvs[2];
  int tv_cyc[2];
  int dout_cnt[2];

  // Core behaviour knobs, set by the stimulus (-1 = random).
  int dvd_delay = -1;
  int dvs_delay = -1;
  int lat = -1;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  // Reference cache contents: last request whose result reached EX.
  bit          m_cv = 1'b0;
  bit          m_sgn = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always #5 clk = ~clk;

  div_sched #(.WIDTH(32), .CACHE_EN(1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .flush                (flush),
    .req_valid            (req_valid),
    .req_signed           (req_signed),
    .req_src1             (req_src1),
    .req_src2             (req_src2),
    .req_ready            (req_ready),
    .resp_valid           (resp_valid),
    .resp_quot            (resp_quot),
    .resp_rem             (resp_rem),
    .resp_ack             (resp_ack),
    .div_dividend_tdata   (dvd_tdata),
    .div_divisor_tdata    (dvs_tdata),
    .sdiv_dividend_tvalid (s_dvd_tv),
    .sdiv_divisor_tvalid  (s_dvs_tv),
    .sdiv_dividend_tready (dvd_rdy[1]),
    .sdiv_divisor_tready  (dvs_rdy[1]),
    .sdiv_dout_tvalid     (dout_v[1]),
    .sdiv_dout_tdata      (dout_d[1]),
    .udiv_dividend_tvalid (u_dvd_tv),
    .udiv_divisor_tvalid  (u_dvs_tv),
    .udiv_dividend_tready (dvd_rdy[0]),
    .udiv_divisor_tready  (dvs_rdy[0]),
    .udiv_dout_tvalid     (dout_v[0]),
    .udiv_dout_tdata      (dout_d[0])
  );

  // Divider IP behaviour: truncating division; x/0 gives all-ones quotient and rem = dividend.
  function automatic logic [63:0] core_result(input bit sgn, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider core models: readies change just after the edge, handshakes are judged mid-cycle.
  initial begin
    bit          got_a[2];
    bit          got_b[2];
    bit          pend[2];
    int          cnt[2];
    int          wa[2];
    int          wb[2];
    logic [31:0] oa[2];
    logic [31:0] ob[2];
    logic        tva, tvb;
    for (int c = 0; c < 2; c++) begin
      got_a[c] = 0; got_b[c] = 0; pend[c] = 0; cnt[c] = 0; wa[c] = 0; wb[c] = 0;
      oa[c] = '0; ob[c] = '0; hs_dvd[c] = 0; hs_dvs[c] = 0; tv_cyc[c] = 0; dout_cnt[c] = 0;
      dvd_rdy[c] = 1'b0; dvs_rdy[c] = 1'b0; dout_v[c] = 1'b0; dout_d[c] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        dout_v[c] = 1'b0;
        if (pend[c]) begin
          cnt[c]--;
          if (cnt[c] == 0) begin
            dout_v[c] = 1'b1;
            dout_d[c] = core_result(c == 1, oa[c], ob[c]);
            dout_cnt[c]++;
            pend[c] = 0;
          end
        end
        dvd_rdy[c] = (dvd_delay < 0) ? 1'($urandom_range(0, 1)) : (wa[c] >= dvd_delay);
        dvs_rdy[c] = (dvs_delay < 0) ? 1'($urandom_range(0, 1)) : (wb[c] >= dvs_delay);
      end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        tva = (c == 1) ? s_dvd_tv : u_dvd_tv;
        tvb = (c == 1) ? s_dvs_tv : u_dvs_tv;
        if (tva || tvb) tv_cyc[c]++;
        if (tva && dvd_rdy[c]) begin
          oa[c] = dvd_tdata; got_a[c] = 1; hs_dvd[c]++; wa[c] = 0;
        end else if (tva) wa[c]++;
        else wa[c] = 0;
        if (tvb && dvs_rdy[c]) begin
          ob[c] = dvs_tdata; got_b[c] = 1; hs_dvs[c]++; wb[c] = 0;
        end else if (tvb) wb[c]++;
        else wb[c] = 0;
        if (got_a[c] && got_b[c]) begin
          got_a[c] = 0;
          got_b[c] = 0;
          pend[c]  = 1;
          cnt[c]   = (lat < 0) ? int'($urandom_range(1, 4)) : lat;
        end
      end
    end
  end

  // Scoreboard monitor: each newly presented response is compared against the queue head.
  initial begin
    logic        prev;
    logic [63:0] held;
    logic [63:0] e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (resp_valid && !prev) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", {resp_quot, resp_rem}, e);
        end
        held = {resp_quot, resp_rem};
      end else if (resp_valid) begin
        chk("resp_stable", {resp_quot, resp_rem}, held);
      end
      prev = resp_valid;
    end
  end

  // plan: 0 normal, 1 flush in WAIT, 2 flush in ISSUE after divisor only, 3 flush in DONE,
  // 4 flush in ISSUE before any handshake. Called and returns just after a rising edge.
  task automatic do_req(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int plan, input int ackd);
    bit  hit;
    int  c, o, n;
    int  b_dvd, b_dvs, b_tvo, b_do;
    c   = sgn ? 1 : 0;
    o   = 1 - c;
    hit = m_cv && (m_sgn == sgn) && (m_a == a) && (m_b == b);
    if (plan == 1) lat = 6;
    if (plan == 2) begin dvd_delay = 4; dvs_delay = 0; end
    if (plan == 4) begin dvd_delay = 5; dvs_delay = 5; end
    req_valid = 1'b1; req_signed = sgn; req_src1 = a; req_src2 = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    b_dvd = hs_dvd[c]; b_dvs = hs_dvs[c]; b_tvo = tv_cyc[o]; b_do = dout_cnt[c];
    if (plan == 0 || plan == 3) begin
      exp_q.push_back(core_result(sgn, a, b));
      m_cv = 1'b1; m_sgn = sgn; m_a = a; m_b = b;
    end
    if (hit) begin
      @(negedge clk);
      chk("hit_latency", 64'(resp_valid), 64'd1);
    end
    case (plan)
      0, 3: begin
        n = 0;
        while (!resp_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
        if (hit) begin
          chk("hit_no_tvalid", 64'(tv_cyc[c] + tv_cyc[o] - b_tvo), 64'(tv_cyc[c]));
          chk("hit_no_hs", 64'(hs_dvd[c] + hs_dvs[c] - b_dvd - b_dvs), 64'd0);
        end else begin
          chk("dvd_handshakes", 64'(hs_dvd[c] - b_dvd), 64'd1);
          chk("dvs_handshakes", 64'(hs_dvs[c] - b_dvs), 64'd1);
          chk("other_core_idle", 64'(tv_cyc[o] - b_tvo), 64'd0);
        end
        req_valid = 1'b1;  // a waiting request must not be taken while the result is held
        for (int i = 0; i < ackd; i++) begin
          @(negedge clk);
          chk("hold_no_accept", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        if (plan == 3) begin
          flush = 1'b1;
          @(posedge clk);
          #1;
          flush = 1'b0;
          @(negedge clk);
          chk("done_flush_drop", 64'(resp_valid), 64'd0);
        end else begin
          resp_ack = 1'b1;
          @(posedge clk);
          #1;
          resp_ack = 1'b0;
          @(negedge clk);
          chk("ack_back_to_idle", 64'(req_ready), 64'd1);
        end
      end
      1: begin
        n = 0;
        while (!((hs_dvd[c] - b_dvd) == 1 && (hs_dvs[c] - b_dvs) == 1) && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n >= 100) chk("issue_timeout", 64'(hs_dvd[c] + hs_dvs[c] - b_dvd - b_dvs), 64'd2);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
          chk("drain_ready_low", 64'(req_ready), 64'd0);
        end while (dout_cnt[c] == b_do && n < 100);
        @(negedge clk);
        chk("drain_exit", 64'(req_ready), 64'd1);
        chk("drain_result_seen", 64'(dout_cnt[c] - b_do), 64'd1);
      end
      2: begin
        n = 0;
        while ((hs_dvs[c] - b_dvs) == 0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("divisor_first", 64'(hs_dvd[c] - b_dvd), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!req_ready && n < 200);
        chk("half_issue_dvd", 64'(hs_dvd[c] - b_dvd), 64'd1);
        chk("half_issue_dvs", 64'(hs_dvs[c] - b_dvs), 64'd1);
        chk("half_issue_drained", 64'(dout_cnt[c] - b_do), 64'd1);
      end
      default: begin
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("issue_flush_idle", 64'(req_ready), 64'd1);
        chk("issue_flush_no_hs", 64'(hs_dvd[c] + hs_dvs[c] - b_dvd - b_dvs), 64'd0);
        chk("issue_flush_tv_low", 64'(s_dvd_tv | s_dvs_tv | u_dvd_tv | u_dvs_tv), 64'd0);
      end
    endcase
    @(posedge clk);
    #1;
    dvd_delay = -1;
    dvs_delay = -1;
    lat = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          sgn, hit;
    logic [31:0] a, b;
    int          plan, sel;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", {resp_quot, resp_rem}, 64'd0);
    chk("rst_tvalids", 64'({s_dvd_tv, s_dvs_tv, u_dvd_tv, u_dvs_tv}), 64'd0);
    @(posedge clk);
    #1;

    do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 3);
    dvd_delay = 3;
    dvs_delay = 0;
    do_req(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_req(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1);
    do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);

    // A request coinciding with a flush in IDLE is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd40; req_src2 = 32'd5; flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_ignored", 64'(req_ready), 64'd1);
    chk("idle_flush_no_tv", 64'(u_dvd_tv | u_dvs_tv), 64'd0);
    @(posedge clk);
    #1;

    do_req(1'b1, 32'd100, 32'd7, 1, 0);
    do_req(1'b1, 32'd9, 32'd3, 0, 0);
    do_req(1'b0, 32'd33, 32'd4, 2, 0);
    do_req(1'b0, 32'd20, 32'd6, 0, 0);
    do_req(1'b1, 32'd50, 32'hFFFF_FFFD, 3, 5);
    do_req(1'b1, 32'd50, 32'hFFFF_FFFD, 0, 0);
    do_req(1'b0, 32'd77, 32'd0, 4, 0);
    do_req(1'b0, 32'd77, 32'd0, 0, 0);
    do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3 && m_cv) begin
        sgn = m_sgn; a = m_a; b = m_b;
      end else begin
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        case (sel)
          3:       b = 32'd0;
          4, 5:    b = 32'($urandom_range(1, 15));
          6:       b = -32'($urandom_range(1, 15));
          default: b = $urandom;
        endcase
      end
      hit = m_cv && (m_sgn == sgn) && (m_a == a) && (m_b == b);
      sel = int'($urandom_range(0, 9));
      if (hit) plan = (sel < 2) ? 3 : 0;
      else plan = (sel < 5) ? 0 : (sel - 5);
      do_req(sgn, a, b, plan, int'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
